// File: rtl/uart_frame_parser.sv
// Collects bytes from the UART receiver into {HEADER, ADDR, DATA, CSUM} frames,
// issues a register-write strobe for frames whose checksum matches, and counts errors.
module uart_frame_parser #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 104160,
  parameter int unsigned TO_W        = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_err,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      addr_q;
  logic [7:0]      data_q;
  logic            timeout;

  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout = (state != IDLE) && !rx_ready && (to_cnt == TO_LAST);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      to_cnt    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      // NOTE: pulse outputs default low here and are overridden below; with
      // non-blocking assignments the last write in the block wins.
      wr_en     <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE || rx_ready || timeout) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (timeout) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end else if (rx_ready) begin
        case (state)
          IDLE: if (rx_data == HEADER) state <= ADDR;
          ADDR: begin
            addr_q <= rx_data;
            state  <= DATA;
          end
          DATA: begin
            data_q <= rx_data;
            state  <= CSUM;
          end
          CSUM: begin
            state <= IDLE;
            if (rx_data == (addr_q ^ data_q)) begin
              wr_en     <= 1'b1;
              wr_addr   <= addr_q;
              wr_data   <= data_q;
              frame_cnt <= frame_cnt + 16'd1;
            end else begin
              frame_err <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized bench for uart_frame_parser: a byte-list model of frame assembly,
// checksum and inter-byte timeout predicts every output cycle by cycle.
module tb_uart_frame_parser;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int         TO  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        frame_err;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: bytes of the open frame and idle cycles since the last one.
  logic [7:0] frame[$];
  int         gap = 0;
  logic       m_wr, m_err;
  logic [7:0] m_addr = '0, m_data = '0, m_ecnt = '0;
  logic [15:0] m_fcnt = '0;

  uart_frame_parser #(.HEADER(HDR), .TIMEOUT_CYC(TO), .TO_W(7)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err),
    .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic note_error();
    m_err = 1'b1;
    if (m_ecnt < 8'hFF) m_ecnt = m_ecnt + 8'd1;
  endtask

  task automatic model(input logic rdy, input logic [7:0] d);
    m_wr  = 1'b0;
    m_err = 1'b0;
    if (rdy) begin
      gap = 0;
      if (frame.size() != 0 || d == HDR) frame.push_back(d);
      if (frame.size() == 4) begin
        if ((frame[1] ^ frame[2]) == frame[3]) begin
          m_wr   = 1'b1;
          m_addr = frame[1];
          m_data = frame[2];
          m_fcnt = m_fcnt + 16'd1;
        end else begin
          note_error();
        end
        frame.delete();
      end
    end else if (frame.size() != 0) begin
      gap++;
      if (gap == TO) begin
        note_error();
        frame.delete();
        gap = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".wr_en"},     wr_en,     m_wr);
    check({tag, ".frame_err"}, frame_err, m_err);
    check({tag, ".busy"},      busy,      frame.size() != 0);
    check({tag, ".wr_addr"},   wr_addr,   m_addr);
    check({tag, ".wr_data"},   wr_data,   m_data);
    check({tag, ".frame_cnt"}, frame_cnt, m_fcnt);
    check({tag, ".err_cnt"},   err_cnt,   m_ecnt);
    check({tag, ".exclusive"}, wr_en & frame_err, 1'b0);
  endtask

  // Called one time unit after a rising edge; applies inputs for one cycle.
  task automatic step(input string tag, input logic rdy, input logic [7:0] d);
    rx_ready = rdy;
    rx_data  = d;
    model(rdy, d);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic send(input string tag, input logic [7:0] b);
    step(tag, 1'b1, b);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'($urandom));
  endtask

  task automatic send_frame(input string tag, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] c, input int max_gap);
    logic [7:0] b[4];
    b[0] = HDR; b[1] = a; b[2] = d; b[3] = c;
    for (int i = 0; i < 4; i++) begin
      send(tag, b[i]);
      if (i < 3 && max_gap > 0) idle(tag, $urandom_range(max_gap, 0));
    end
  endtask

  task automatic do_reset(input string tag, input int cycles);
    rx_ready = 1'b0;
    rst = 1'b0;
    #1;
    frame.delete();
    gap = 0; m_wr = 0; m_err = 0;
    m_addr = '0; m_data = '0; m_fcnt = '0; m_ecnt = '0;
    check_outputs({tag, ".async"});
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] a, d, c;
    int kind;

    m_wr = 0; m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b1;

    // Good frame, then a bad-checksum frame.
    send_frame("good", 8'h12, 8'h34, 8'h26, 0);
    idle("good_tail", 2);
    send_frame("bad", 8'h12, 8'h34, 8'h27, 0);
    idle("bad_tail", 2);

    // Junk before a frame is ignored silently.
    send("junk", 8'h00); send("junk", 8'hFF); send("junk", 8'h5A);
    send_frame("after_junk", 8'h01, 8'h02, 8'h03, 0);

    // Timeout after two bytes, then a clean frame.
    send("to", HDR); send("to", 8'h12);
    idle("to_wait", TO + 2);
    send_frame("post_to", 8'h01, 8'h02, 8'h03, 0);

    // A byte on the last allowed cycle wins over the timeout.
    send("edge", HDR);
    idle("edge_wait", TO - 1);
    send("edge", 8'h44);
    idle("edge_wait", TO - 1);
    send("edge", 8'h11);
    send("edge", 8'h55);

    // HEADER as address is accepted (no resync).
    send_frame("hdr_addr", HDR, 8'h0F, HDR ^ 8'h0F, 0);

    // Reset mid-frame discards the partial frame.
    send("rst_mid", HDR); send("rst_mid", 8'h12); send("rst_mid", 8'h34);
    do_reset("rst_mid", 3);
    send("rst_after", 8'h56);
    idle("rst_after", 3);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) send_frame("sat", 8'h10, 8'h20, 8'h31, 0);
    check("sat.final", err_cnt, 8'hFF);
    do_reset("rst2", 2);

    // Randomized mix of good, bad, junk, timeout-boundary frames.
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(9, 0);
      a = 8'($urandom); d = 8'($urandom);
      c = (kind < 5) ? (a ^ d) : 8'($urandom);
      if (kind == 9) begin
        send("rnd_junk", 8'($urandom));
      end else if (kind == 8) begin
        send("rnd_to", HDR);
        idle("rnd_to", $urandom_range(TO + 1, TO - 2));
        send_frame("rnd_to", a, d, a ^ d, 0);
      end else begin
        send_frame("rnd", a, d, c, (kind == 7) ? 4 : 0);
      end
      if ($urandom_range(1, 0) == 1) idle("rnd_gap", $urandom_range(3, 0));
    end
    idle("drain", TO + 2);
    check("final.busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
